// File: rtl/lstm_bp_delta_if.sv
// lstm_bp_delta_if
//   Start/valid handshake and data bus of the LSTM backward-pass delta unit.
//   master : requester; drives i_start and the forward-pass operands, reads the results.
//   slave  : delta unit; reads the operands, drives o_busy/o_valid and the deltas.
//   All data words are signed fixed point, WIDTH bits wide.
interface lstm_bp_delta_if #(
   parameter int WIDTH = 24
);
   logic                    i_start;
   logic signed [WIDTH-1:0] i_dh;
   logic signed [WIDTH-1:0] i_dstate_next;
   logic signed [WIDTH-1:0] i_f_next;
   logic signed [WIDTH-1:0] i_a;
   logic signed [WIDTH-1:0] i_i;
   logic signed [WIDTH-1:0] i_f;
   logic signed [WIDTH-1:0] i_o;
   logic signed [WIDTH-1:0] i_tanh_c;
   logic signed [WIDTH-1:0] i_c_prev;
   logic                    o_busy;
   logic                    o_valid;
   logic signed [WIDTH-1:0] o_dstate;
   logic signed [WIDTH-1:0] o_da;
   logic signed [WIDTH-1:0] o_di;
   logic signed [WIDTH-1:0] o_df;
   logic signed [WIDTH-1:0] o_do;

   modport master (
      output i_start, i_dh, i_dstate_next, i_f_next, i_a, i_i, i_f, i_o, i_tanh_c, i_c_prev,
      input  o_busy, o_valid, o_dstate, o_da, o_di, o_df, o_do
   );

   modport slave (
      input  i_start, i_dh, i_dstate_next, i_f_next, i_a, i_i, i_f, i_o, i_tanh_c, i_c_prev,
      output o_busy, o_valid, o_dstate, o_da, o_di, o_df, o_do
   );
endinterface

// File: rtl/lstm_bp_delta.sv
// lstm_bp_delta
//   Backward pass of one LSTM unit at one timestep: dstate(t) and the four
//   pre-activation gate deltas, computed with a single shared saturating
//   fixed-point multiplier stepped through a 16-entry schedule.
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : lstm_bp_delta_if.slave
//          i_start request (taken only when idle), forward operands in,
//          o_busy / o_valid status, o_dstate and o_da/o_di/o_df/o_do out.
//
// state  | meaning
// IDLE   | waiting for i_start; operands latched on acceptance
// CALC   | one multiply per cycle, step 0..15
// DONE   | all deltas ready; commit to outputs, o_valid pulses next cycle
module lstm_bp_delta #(
   parameter int WIDTH = 24,
   parameter int FRAC  = 20
) (
   input  logic            clk,
   input  logic            rst,
   lstm_bp_delta_if.slave  bus
);
   localparam int PW = 2 * WIDTH;
   localparam int AW = WIDTH + 1;
   localparam logic signed [WIDTH-1:0] ONE  = {{(WIDTH-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
   localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   function automatic logic signed [WIDTH-1:0] sat_mul(input logic signed [WIDTH-1:0] x,
                                                       input logic signed [WIDTH-1:0] y);
      logic signed [PW-1:0] p;
      logic signed [PW-1:0] s;
      p = PW'(x) * PW'(y);
      s = p >>> FRAC;
      // in range only when every bit above the result sign matches it
      if (s[PW-1:WIDTH-1] == '0 || s[PW-1:WIDTH-1] == '1) return s[WIDTH-1:0];
      return s[PW-1] ? MINV : MAXV;
   endfunction

   function automatic logic signed [WIDTH-1:0] sat_add(input logic signed [WIDTH-1:0] x,
                                                       input logic signed [WIDTH-1:0] y);
      logic signed [AW-1:0] s;
      s = AW'(x) + AW'(y);
      if (s[AW-1] != s[AW-2]) return s[AW-1] ? MINV : MAXV;
      return s[WIDTH-1:0];
   endfunction

   function automatic logic signed [WIDTH-1:0] sat_sub(input logic signed [WIDTH-1:0] x,
                                                       input logic signed [WIDTH-1:0] y);
      logic signed [AW-1:0] s;
      s = AW'(x) - AW'(y);
      if (s[AW-1] != s[AW-2]) return s[AW-1] ? MINV : MAXV;
      return s[WIDTH-1:0];
   endfunction

   state_t                  state_q, state_d;
   logic [3:0]              step_q, step_d;
   logic                    busy_q, busy_d;
   logic                    valid_q, valid_d;
   logic signed [WIDTH-1:0] dh_q, dh_d, dsn_q, dsn_d, fn_q, fn_d, ag_q, ag_d, ig_q, ig_d;
   logic signed [WIDTH-1:0] fg_q, fg_d, og_q, og_d, tc_q, tc_d, cp_q, cp_d;
   logic signed [WIDTH-1:0] t_q [1:12];
   logic signed [WIDTH-1:0] t_d [1:12];
   logic signed [WIDTH-1:0] dstate_q, dstate_d, da_q, da_d, di_q, di_d, df_q, df_d, dd_q, dd_d;
   logic signed [WIDTH-1:0] out_dstate_q, out_dstate_d, out_da_q, out_da_d, out_di_q, out_di_d;
   logic signed [WIDTH-1:0] out_df_q, out_df_d, out_do_q, out_do_d;

   logic signed [WIDTH-1:0] om_x, om_y, mul_a, mul_b, mul_y;

   // shared (ONE - x) operand for the derivative terms
   always_comb begin
      om_x = '0;
      case (step_q)
         4'd2:    om_x = t_q[1];
         4'd6:    om_x = t_q[5];
         4'd7:    om_x = ig_q;
         4'd10:   om_x = fg_q;
         4'd13:   om_x = og_q;
         default: om_x = '0;
      endcase
   end

   assign om_y = sat_sub(ONE, om_x);

   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (step_q)
         4'd0:  begin mul_a = tc_q;     mul_b = tc_q;   end
         4'd1:  begin mul_a = dh_q;     mul_b = og_q;   end
         4'd2:  begin mul_a = t_q[2];   mul_b = om_y;   end
         4'd3:  begin mul_a = dsn_q;    mul_b = fn_q;   end
         4'd4:  begin mul_a = ag_q;     mul_b = ag_q;   end
         4'd5:  begin mul_a = dstate_q; mul_b = ig_q;   end
         4'd6:  begin mul_a = t_q[6];   mul_b = om_y;   end
         4'd7:  begin mul_a = ig_q;     mul_b = om_y;   end
         4'd8:  begin mul_a = dstate_q; mul_b = ag_q;   end
         4'd9:  begin mul_a = t_q[8];   mul_b = t_q[7]; end
         4'd10: begin mul_a = fg_q;     mul_b = om_y;   end
         4'd11: begin mul_a = dstate_q; mul_b = cp_q;   end
         4'd12: begin mul_a = t_q[10];  mul_b = t_q[9]; end
         4'd13: begin mul_a = og_q;     mul_b = om_y;   end
         4'd14: begin mul_a = dh_q;     mul_b = tc_q;   end
         4'd15: begin mul_a = t_q[12];  mul_b = t_q[11]; end
         default: begin mul_a = '0;     mul_b = '0;     end
      endcase
   end

   assign mul_y = sat_mul(mul_a, mul_b);

   always_comb begin
      state_d = state_q;  step_d = step_q;  valid_d = 1'b0;
      dh_d = dh_q;  dsn_d = dsn_q;  fn_d = fn_q;  ag_d = ag_q;  ig_d = ig_q;
      fg_d = fg_q;  og_d = og_q;  tc_d = tc_q;  cp_d = cp_q;
      t_d = t_q;
      dstate_d = dstate_q;  da_d = da_q;  di_d = di_q;  df_d = df_q;  dd_d = dd_q;
      out_dstate_d = out_dstate_q;  out_da_d = out_da_q;  out_di_d = out_di_q;
      out_df_d = out_df_q;  out_do_d = out_do_q;
      case (state_q)
         S_IDLE: begin
            if (bus.i_start) begin
               dh_d = bus.i_dh;  dsn_d = bus.i_dstate_next;  fn_d = bus.i_f_next;
               ag_d = bus.i_a;   ig_d = bus.i_i;   fg_d = bus.i_f;   og_d = bus.i_o;
               tc_d = bus.i_tanh_c;  cp_d = bus.i_c_prev;
               step_d  = 4'd0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            step_d = step_q + 4'd1;
            case (step_q)
               4'd0:  t_d[1]  = mul_y;
               4'd1:  t_d[2]  = mul_y;
               4'd2:  t_d[3]  = mul_y;
               4'd3:  t_d[4]  = mul_y;
               4'd4:  begin t_d[5] = mul_y; dstate_d = sat_add(t_q[3], t_q[4]); end
               4'd5:  t_d[6]  = mul_y;
               4'd6:  da_d    = mul_y;
               4'd7:  t_d[7]  = mul_y;
               4'd8:  t_d[8]  = mul_y;
               4'd9:  di_d    = mul_y;
               4'd10: t_d[9]  = mul_y;
               4'd11: t_d[10] = mul_y;
               4'd12: df_d    = mul_y;
               4'd13: t_d[11] = mul_y;
               4'd14: t_d[12] = mul_y;
               4'd15: begin dd_d = mul_y; state_d = S_DONE; end
               default: ;
            endcase
         end
         S_DONE: begin
            // every delta lands in the output registers on the same edge as o_valid
            out_dstate_d = dstate_q;  out_da_d = da_q;  out_di_d = di_q;
            out_df_d = df_q;  out_do_d = dd_q;
            valid_d = 1'b1;
            step_d  = 4'd0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;  step_q <= '0;  busy_q <= 1'b0;  valid_q <= 1'b0;
         dh_q <= '0;  dsn_q <= '0;  fn_q <= '0;  ag_q <= '0;  ig_q <= '0;
         fg_q <= '0;  og_q <= '0;  tc_q <= '0;  cp_q <= '0;
         for (int k = 1; k <= 12; k++) t_q[k] <= '0;
         dstate_q <= '0;  da_q <= '0;  di_q <= '0;  df_q <= '0;  dd_q <= '0;
         out_dstate_q <= '0;  out_da_q <= '0;  out_di_q <= '0;  out_df_q <= '0;  out_do_q <= '0;
      end else begin
         state_q <= state_d;  step_q <= step_d;  busy_q <= busy_d;  valid_q <= valid_d;
         dh_q <= dh_d;  dsn_q <= dsn_d;  fn_q <= fn_d;  ag_q <= ag_d;  ig_q <= ig_d;
         fg_q <= fg_d;  og_q <= og_d;  tc_q <= tc_d;  cp_q <= cp_d;
         t_q <= t_d;
         dstate_q <= dstate_d;  da_q <= da_d;  di_q <= di_d;  df_q <= df_d;  dd_q <= dd_d;
         out_dstate_q <= out_dstate_d;  out_da_q <= out_da_d;  out_di_q <= out_di_d;
         out_df_q <= out_df_d;  out_do_q <= out_do_d;
      end
   end

   assign bus.o_busy   = busy_q;
   assign bus.o_valid  = valid_q;
   assign bus.o_dstate = out_dstate_q;
   assign bus.o_da     = out_da_q;
   assign bus.o_di     = out_di_q;
   assign bus.o_df     = out_df_q;
   assign bus.o_do     = out_do_q;
endmodule

// File: tb/tb_lstm_bp_delta.sv
// tb_lstm_bp_delta
//   Directed and random checks of lstm_bp_delta against a plain-arithmetic
//   model of the backward-pass equations (saturating Q3.20, floor shift).
module tb_lstm_bp_delta;
   typedef struct {
      logic signed [23:0] dh, dsn, fn, a, i, f, o, tc, cp;
   } vec_t;

   typedef struct {
      logic [23:0] ds, da, di, df, dd;
   } res_t;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   res_t prev;

   lstm_bp_delta_if #(.WIDTH(24)) bus ();

   lstm_bp_delta #(.WIDTH(24), .FRAC(20)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic longint clampm(input longint v);
      if (v > 64'sd8388607) return 64'sd8388607;
      if (v < -64'sd8388608) return -64'sd8388608;
      return v;
   endfunction

   function automatic longint mulm(input longint x, input longint y);
      longint p;
      p = x * y;
      return clampm(p >>> 20);
   endfunction

   function automatic longint addm(input longint x, input longint y);
      return clampm(x + y);
   endfunction

   function automatic longint subm(input longint x, input longint y);
      return clampm(x - y);
   endfunction

   function automatic res_t model(input vec_t v);
      longint one, dh, dsn, fn, a, i, f, o, tc, cp, ds;
      res_t r;
      one = 64'sd1 <<< 20;
      dh = longint'(v.dh);  dsn = longint'(v.dsn);  fn = longint'(v.fn);
      a = longint'(v.a);  i = longint'(v.i);  f = longint'(v.f);  o = longint'(v.o);
      tc = longint'(v.tc);  cp = longint'(v.cp);
      ds = addm(mulm(mulm(dh, o), subm(one, mulm(tc, tc))), mulm(dsn, fn));
      r.ds = 24'(ds);
      r.da = 24'(mulm(mulm(ds, i), subm(one, mulm(a, a))));
      r.di = 24'(mulm(mulm(ds, a), mulm(i, subm(one, i))));
      r.df = 24'(mulm(mulm(ds, cp), mulm(f, subm(one, f))));
      r.dd = 24'(mulm(mulm(dh, tc), mulm(o, subm(one, o))));
      return r;
   endfunction

   function automatic vec_t rand_vec();
      vec_t v;
      v.dh = 24'($urandom);  v.dsn = 24'($urandom);  v.fn = 24'($urandom);
      v.a = 24'($urandom);   v.i = 24'($urandom);    v.f = 24'($urandom);
      v.o = 24'($urandom);   v.tc = 24'($urandom);   v.cp = 24'($urandom);
      return v;
   endfunction

   task automatic apply(input vec_t v);
      bus.i_dh = v.dh;  bus.i_dstate_next = v.dsn;  bus.i_f_next = v.fn;
      bus.i_a = v.a;  bus.i_i = v.i;  bus.i_f = v.f;  bus.i_o = v.o;
      bus.i_tanh_c = v.tc;  bus.i_c_prev = v.cp;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_res(input string tag, input res_t e);
      check({tag, "/dstate"}, {8'h0, bus.o_dstate}, {8'h0, e.ds});
      check({tag, "/da"},     {8'h0, bus.o_da},     {8'h0, e.da});
      check({tag, "/di"},     {8'h0, bus.o_di},     {8'h0, e.di});
      check({tag, "/df"},     {8'h0, bus.o_df},     {8'h0, e.df});
      check({tag, "/do"},     {8'h0, bus.o_do},     {8'h0, e.dd});
   endtask

   function automatic bit same_res(input res_t e);
      return bus.o_dstate === e.ds && bus.o_da === e.da && bus.o_di === e.di &&
             bus.o_df === e.df && bus.o_do === e.dd;
   endfunction

   // Call between edges; counts rising edges until o_valid is seen (0 on timeout).
   task automatic wait_valid(input res_t hold, output int n, output bit stable, output bit busy_ok);
      n = 0;  stable = 1'b1;  busy_ok = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (bus.o_valid === 1'b1) begin
            n = c;
            break;
         end
         if (bus.o_busy !== 1'b1) busy_ok = 1'b0;
         if (!same_res(hold)) stable = 1'b0;
      end
   endtask

   task automatic run_vec(input string tag, input vec_t v, input res_t e);
      int n;
      bit stable, busy_ok;
      @(negedge clk);
      apply(v);
      bus.i_start = 1'b1;
      @(posedge clk); #1;
      check({tag, "/busy_rise"}, 32'(bus.o_busy), 32'd1);
      @(negedge clk);
      bus.i_start = 1'b0;
      apply(rand_vec());
      wait_valid(prev, n, stable, busy_ok);
      check({tag, "/latency"}, n, 32'd17);
      check({tag, "/busy_until_valid"}, 32'(busy_ok), 32'd1);
      check({tag, "/hold_prev"}, 32'(stable), 32'd1);
      check({tag, "/busy_at_valid"}, 32'(bus.o_busy), 32'd0);
      check_res(tag, e);
      @(posedge clk); #1;
      check({tag, "/valid_width"}, 32'(bus.o_valid), 32'd0);
      prev = e;
   endtask

   initial begin
      vec_t c1, v, v2;
      res_t e1, e, e2;
      int   pulses[$];
      int   n, cnt;
      bit   stable, busy_ok;

      errors = 0;
      checks = 0;
      prev = '{default: 24'h0};
      rst = 1'b1;
      bus.i_start = 1'b0;
      apply('{default: 24'sh0});

      repeat (2) @(posedge clk);
      #1;
      check("reset/busy", 32'(bus.o_busy), 32'd0);
      check("reset/valid", 32'(bus.o_valid), 32'd0);
      check_res("reset", prev);
      @(negedge clk);
      rst = 1'b0;

      // directed: nominal values
      c1 = '{dh: 24'sh100000, dsn: 24'sh0, fn: 24'sh0, a: 24'sh080000, i: 24'sh080000,
             f: 24'sh080000, o: 24'sh080000, tc: 24'sh080000, cp: 24'sh100000};
      e1 = '{ds: 24'h060000, da: 24'h024000, di: 24'h00C000, df: 24'h018000, dd: 24'h020000};
      run_vec("nominal", c1, e1);

      // directed: saturation of the dstate sum
      v = '{dh: 24'sh7FFFFF, dsn: 24'sh7FFFFF, fn: 24'sh100000, a: 24'sh0, i: 24'sh0,
            f: 24'sh0, o: 24'sh100000, tc: 24'sh0, cp: 24'sh0};
      e = model(v);
      check("sat/model_ds", {8'h0, e.ds}, 32'h007FFFFF);
      run_vec("sat", v, e);

      // directed: floor rounding of a negative product
      v = '{dh: 24'shFFFFFF, dsn: 24'sh0, fn: 24'sh0, a: 24'sh0, i: 24'sh0,
            f: 24'sh0, o: 24'sh080000, tc: 24'sh0, cp: 24'sh0};
      e = '{ds: 24'hFFFFFF, da: 24'h0, di: 24'h0, df: 24'h0, dd: 24'h0};
      run_vec("floor", v, e);

      // directed: ONE - (-8.0) saturates
      v = '{dh: 24'sh100000, dsn: 24'sh0, fn: 24'sh0, a: 24'sh800000, i: 24'sh100000,
            f: 24'sh800000, o: 24'sh800000, tc: 24'sh100000, cp: 24'sh100000};
      run_vec("neg8", v, model(v));

      // i_start held high: one result every 18 cycles, mid-run starts ignored
      v = rand_vec();
      e = model(v);
      @(negedge clk);
      apply(v);
      bus.i_start = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(posedge clk); #1;
         if (bus.o_valid === 1'b1) begin
            pulses.push_back(c);
            check("hold_start/result", 32'(same_res(e)), 32'd1);
         end
      end
      check("hold_start/pulses", pulses.size(), 32'd3);
      check("hold_start/first", (pulses.size() > 0) ? pulses[0] : -1, 32'd17);
      check("hold_start/gap1", (pulses.size() > 1) ? pulses[1] - pulses[0] : -1, 32'd18);
      check("hold_start/gap2", (pulses.size() > 2) ? pulses[2] - pulses[1] : -1, 32'd18);
      @(negedge clk);
      bus.i_start = 1'b0;
      wait_valid(e, n, stable, busy_ok);
      check("hold_start/drain", n, 32'd12);
      check_res("hold_start/drain", e);
      @(posedge clk); #1;
      prev = e;

      // reset in the middle of a calculation
      @(negedge clk);
      apply(c1);
      bus.i_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.i_start = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst/busy", 32'(bus.o_busy), 32'd0);
      check("midrst/valid", 32'(bus.o_valid), 32'd0);
      check_res("midrst", '{default: 24'h0});
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      for (int c = 0; c < 25; c++) begin
         @(posedge clk); #1;
         if (bus.o_valid === 1'b1) cnt++;
      end
      check("midrst/no_valid", cnt, 32'd0);
      prev = '{default: 24'h0};
      run_vec("after_rst", c1, e1);

      // back-to-back: second start on the cycle o_valid falls
      v = rand_vec();
      v2 = rand_vec();
      e = model(v);
      e2 = model(v2);
      run_vec("b2b_1", v, e);
      @(negedge clk);
      apply(v2);
      bus.i_start = 1'b1;
      @(posedge clk); #1;
      check("b2b/busy", 32'(bus.o_busy), 32'd1);
      @(negedge clk);
      bus.i_start = 1'b0;
      apply(rand_vec());
      wait_valid(e, n, stable, busy_ok);
      check("b2b_2/latency", n, 32'd17);
      check("b2b_2/hold_prev", 32'(stable), 32'd1);
      check_res("b2b_2", e2);
      prev = e2;

      // random vectors
      for (int k = 0; k < 6; k++) begin
         v = rand_vec();
         run_vec($sformatf("rand%0d", k), v, model(v));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
